// File: rtl/exec_pkg.sv
// Shared types for the execute front end: instruction layout, opselect encoding
// and the bit positions of the control_in bundle.
package exec_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int INSTR_WIDTH    = 32;

    typedef enum logic [2:0] {
        SHIFT_REG   = 3'b000,
        ARITH_LOGIC = 3'b001,
        MEM_WRITE   = 3'b100,
        MEM_READ    = 3'b101
    } opselect_t;

    localparam int CTL_IMMP      = 0;
    localparam int CTL_OP_LSB    = 1;
    localparam int CTL_OPSEL_LSB = 4;
    localparam int CTL_WIDTH     = 7;

    // imm is instr[14:0], so it spans the rs2 field plus imm_lo
    typedef struct packed {
        logic       immp_regn;
        logic [2:0] opselect;
        logic [2:0] operation;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [9:0] imm_lo;
    } instr_t;

    function automatic logic is_legal(logic [2:0] os);
        case (os)
            SHIFT_REG, ARITH_LOGIC, MEM_WRITE, MEM_READ: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, same-cycle
// writeback forwarded into the hazard check, set beats clear on collision.
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    localparam int IW = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic [IW-1:0] rs1,
    input  logic [IW-1:0] rs2,
    input  logic [IW-1:0] rd,
    input  logic          chk_rs2,
    input  logic          chk_rd,
    output logic          hazard
);

    logic [NUM_REGS-1:0] busy, pend, clr_mask, set_mask;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        if (set_en) set_mask[set_idx] = 1'b1;
        pend   = busy & ~clr_mask;
        hazard = pend[rs1] || (chk_rs2 && pend[rs2]) || (chk_rd && pend[rd]);
    end

    // r0 is never pending, so bit 0 is pinned low
    always_ff @(posedge clock) begin
        if (reset) busy <= '0;
        else       busy <= {pend[NUM_REGS-1:1] | set_mask[NUM_REGS-1:1], 1'b0};
    end

endmodule

// File: rtl/instr_decode_issue.sv
// Decode/issue stage: decodes one instruction per cycle, reads operands and
// registers the execute input bundle, stalling on scoreboard hazards.
module instr_decode_issue
    import exec_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             instr_valid,
    input  logic [INSTR_WIDTH-1:0]           instr_in,
    output logic                             instr_ready,
    output logic [4:0]                       rf_raddr1,
    output logic [4:0]                       rf_raddr2,
    input  logic [REGISTER_WIDTH-1:0]        rf_rdata1,
    input  logic [REGISTER_WIDTH-1:0]        rf_rdata2,
    input  logic                             wb_valid,
    input  logic [4:0]                       wb_rd,
    output logic signed [REGISTER_WIDTH-1:0] src1,
    output logic signed [REGISTER_WIDTH-1:0] src2,
    output logic [REGISTER_WIDTH-1:0]        imm,
    output logic [CTL_WIDTH-1:0]             control_in,
    output logic                             enable_ex,
    output logic [4:0]                       ex_rd,
    output logic                             illegal_instr
);

    instr_t ins;
    logic   legal, uses_rs2, writes_rd, sb_hazard, accept, issue;

    assign ins       = instr_t'(instr_in);
    assign rf_raddr1 = ins.rs1;
    assign rf_raddr2 = ins.rs2;
    assign legal     = is_legal(ins.opselect);
    assign uses_rs2  = !ins.immp_regn || (ins.opselect == MEM_WRITE);
    assign writes_rd = (ins.opselect != MEM_WRITE) && (ins.rd != '0);

    // illegal instructions bypass the hazard check and drain immediately
    assign instr_ready = !reset && !(legal && sb_hazard);
    assign accept      = instr_valid && instr_ready;
    assign issue       = accept && legal;

    issue_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clock   (clock),
        .reset   (reset),
        .set_en  (issue && writes_rd),
        .set_idx (ins.rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .rs1     (ins.rs1),
        .rs2     (ins.rs2),
        .rd      (ins.rd),
        .chk_rs2 (uses_rs2),
        .chk_rd  (writes_rd),
        .hazard  (sb_hazard)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            src1          <= '0;
            src2          <= '0;
            imm           <= '0;
            control_in    <= '0;
            ex_rd         <= '0;
            enable_ex     <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            enable_ex     <= issue;
            illegal_instr <= accept && !legal;
            if (issue) begin
                src1       <= (ins.rs1 == '0) ? '0 : rf_rdata1;
                src2       <= (ins.rs2 == '0) ? '0 : rf_rdata2;
                imm        <= {{(REGISTER_WIDTH-15){ins.rs2[4]}}, ins.rs2, ins.imm_lo};
                control_in <= {ins.opselect, ins.operation, ins.immp_regn};
                ex_rd      <= ins.rd;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_issue.sv
// Self-checking bench: a pending-set model checked every cycle plus directed
// literal expectations for the hazard, collision, illegal and reset cases.
module tb_instr_decode_issue;

    logic        clock = 1'b0;
    logic        reset, instr_valid, wb_valid;
    logic [31:0] instr_in;
    logic [4:0]  wb_rd, rf_raddr1, rf_raddr2, ex_rd;
    logic [31:0] rf_rdata1, rf_rdata2, src1, src2, imm;
    logic [6:0]  control_in;
    logic        instr_ready, enable_ex, illegal_instr;

    always #5 clock = ~clock;

    instr_decode_issue dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .src1(src1), .src2(src2), .imm(imm), .control_in(control_in),
        .enable_ex(enable_ex), .ex_rd(ex_rd), .illegal_instr(illegal_instr)
    );

    logic [31:0] rf [32];
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = i * 16 + 1;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 5;
        rf[2] = 7;
        rf[3] = 33;
        rf[6] = -9;
    end
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(bit immp, logic [2:0] os, logic [2:0] op,
                                       logic [4:0] rd, logic [4:0] rs1, logic [14:0] lo);
        return {immp, os, op, rd, rs1, lo};
    endfunction

    // model: set of pending registers and the expected execute bundle
    bit          pend_m [32];
    logic [31:0] m_src1, m_src2, m_imm;
    logic [6:0]  m_ctl;
    logic [4:0]  m_rd;
    logic        m_en, m_ill;
    bit          started = 0;

    function automatic bit legal_m(logic [2:0] os);
        return os == 3'd0 || os == 3'd1 || os == 3'd4 || os == 3'd5;
    endfunction

    function automatic bit busy_m(logic [4:0] r);
        return r != 0 && pend_m[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit ready_m();
        logic [2:0] os;
        bit needs_rs2, dest;
        os = instr_in[30:28];
        if (reset) return 0;
        if (!legal_m(os)) return 1;
        needs_rs2 = !instr_in[31] || os == 3'd4;
        dest      = os != 3'd4 && instr_in[24:20] != 0;
        if (busy_m(instr_in[19:15])) return 0;
        if (needs_rs2 && busy_m(instr_in[14:10])) return 0;
        if (dest && busy_m(instr_in[24:20])) return 0;
        return 1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            started <= 1;
            for (int i = 0; i < 32; i++) pend_m[i] <= 0;
            {m_src1, m_src2, m_imm, m_ctl, m_rd, m_en, m_ill} <= '0;
        end else begin
            m_en  <= 0;
            m_ill <= 0;
            if (wb_valid) pend_m[wb_rd] <= 0;
            if (instr_valid && ready_m()) begin
                if (legal_m(instr_in[30:28])) begin
                    m_en   <= 1;
                    m_src1 <= instr_in[19:15] == 0 ? 32'd0 : rf[instr_in[19:15]];
                    m_src2 <= instr_in[14:10] == 0 ? 32'd0 : rf[instr_in[14:10]];
                    m_imm  <= 32'(signed'(instr_in[14:0]));
                    m_ctl  <= {instr_in[30:25], instr_in[31]};
                    m_rd   <= instr_in[24:20];
                    if (instr_in[30:28] != 3'd4 && instr_in[24:20] != 0)
                        pend_m[instr_in[24:20]] <= 1;
                end else begin
                    m_ill <= 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("m_ready", instr_ready, ready_m());
            chk("m_raddr1", rf_raddr1, instr_in[19:15]);
            chk("m_raddr2", rf_raddr2, instr_in[14:10]);
            chk("m_en", enable_ex, m_en);
            chk("m_ill", illegal_instr, m_ill);
            chk("m_src1", src1, m_src1);
            chk("m_src2", src2, m_src2);
            chk("m_imm", imm, m_imm);
            chk("m_ctl", control_in, m_ctl);
            chk("m_rd", ex_rd, m_rd);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic neg;
        @(negedge clock);
    endtask

    initial begin
        reset = 1; instr_valid = 1; wb_valid = 0; wb_rd = 0;
        instr_in = mk(0, 3'b001, 3'b000, 5'd3, 5'd1, {5'd2, 10'd0});
        neg;
        chk("rst_ready", instr_ready, 0); chk("rst_en", enable_ex, 0);
        chk("rst_src1", src1, 0); chk("rst_ctl", control_in, 0);
        tick; neg;
        chk("rst2_ready", instr_ready, 0); chk("rst2_imm", imm, 0);
        chk("rst2_ill", illegal_instr, 0); chk("rst2_rd", ex_rd, 0);

        tick; reset = 0; neg;
        chk("add_ready", instr_ready, 1);
        tick; instr_in = mk(1, 3'b001, 3'b000, 5'd4, 5'd1, 15'h7FFF); neg;
        chk("add_en", enable_ex, 1); chk("add_src1", src1, 5); chk("add_src2", src2, 7);
        chk("add_ctl", control_in, 7'b0010000); chk("add_rd", ex_rd, 3);
        chk("addi_ready", instr_ready, 1);
        tick; instr_valid = 0; neg;
        chk("addi_en", enable_ex, 1); chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_ctl0", control_in[0], 1); chk("addi_rd", ex_rd, 4);

        // RAW on r3
        tick; instr_valid = 1; instr_in = mk(0, 3'b001, 3'b001, 5'd5, 5'd3, {5'd1, 10'd0}); neg;
        chk("raw_en0", enable_ex, 0); chk("raw_hold", src1, 5); chk("raw_stall", instr_ready, 0);
        tick; neg;
        chk("raw_stall2", instr_ready, 0);
        tick; wb_valid = 1; wb_rd = 3; neg;
        chk("raw_fwd", instr_ready, 1);
        tick; wb_valid = 0; instr_in = mk(0, 3'b001, 3'b010, 5'd3, 5'd1, {5'd2, 10'd0}); neg;
        chk("raw_en", enable_ex, 1); chk("raw_src1", src1, 33); chk("raw_src2", src2, 5);
        chk("raw_rd", ex_rd, 5);

        // set/clear collision on r3
        tick; instr_in = mk(0, 3'b001, 3'b011, 5'd3, 5'd1, {5'd2, 10'd0}); wb_valid = 1; wb_rd = 3; neg;
        chk("col_ready", instr_ready, 1);
        tick; wb_valid = 0; instr_in = mk(0, 3'b001, 3'b000, 5'd6, 5'd3, {5'd1, 10'd0}); neg;
        chk("col_stall", instr_ready, 0); chk("col_ctl", control_in, 7'b0010110);
        tick; neg;
        chk("col_stall2", instr_ready, 0);
        tick; wb_valid = 1; wb_rd = 3; neg;
        chk("col_release", instr_ready, 1);

        // illegal opselect with a pending rs1
        tick; wb_valid = 0; instr_in = mk(0, 3'b010, 3'b000, 5'd7, 5'd4, {5'd5, 10'd0}); neg;
        chk("ill_ready", instr_ready, 1); chk("ill_prev_rd", ex_rd, 6);
        tick; instr_valid = 0; neg;
        chk("ill_pulse", illegal_instr, 1); chk("ill_en", enable_ex, 0); chk("ill_hold", ex_rd, 6);
        tick; instr_valid = 1; instr_in = mk(1, 3'b001, 3'b000, 5'd8, 5'd7, 15'd0); neg;
        chk("ill_one", illegal_instr, 0); chk("ill_nosb", instr_ready, 1);

        // MEM_WRITE waits on rs2 even with immp set, and sets nothing
        tick; instr_in = mk(1, 3'b100, 3'b000, 5'd9, 5'd1, {5'd6, 10'd0}); neg;
        chk("mw_stall", instr_ready, 0);
        tick; wb_valid = 1; wb_rd = 6; neg;
        chk("mw_fwd", instr_ready, 1);
        tick; wb_valid = 0; instr_in = mk(1, 3'b001, 3'b000, 5'd10, 5'd9, 15'd0); neg;
        chk("mw_en", enable_ex, 1); chk("mw_src2", src2, 32'hFFFF_FFF7);
        chk("mw_ctl", control_in, 7'b1000001); chk("mw_imm", imm, 32'h1800);
        chk("mw_nosb", instr_ready, 1);

        // r0 operands, with a harmless writeback of r0
        tick; instr_in = mk(0, 3'b000, 3'b000, 5'd11, 5'd0, 15'd0); wb_valid = 1; wb_rd = 0; neg;
        chk("r0_ready", instr_ready, 1);
        tick; wb_valid = 0; instr_in = mk(0, 3'b001, 3'b000, 5'd12, 5'd4, {5'd1, 10'd0}); neg;
        chk("r0_src1", src1, 0); chk("r0_src2", src2, 0); chk("r0_ctl", control_in, 0);
        chk("r4_stall", instr_ready, 0);

        // reset while stalled drops the instruction and clears the scoreboard
        tick; reset = 1; neg;
        chk("mid_ready", instr_ready, 0); chk("mid_en", enable_ex, 0);
        tick; reset = 0; neg;
        chk("post_ready", instr_ready, 1); chk("post_src1", src1, 0);
        tick; instr_valid = 0; neg;
        chk("post_en", enable_ex, 1); chk("post_rd", ex_rd, 12); chk("post_src1v", src1, 65);
        tick; neg;
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
